leaf_stream_packer: RTL

//  Transmit-side counterpart of the leaf receive path: consumes a user-side ap_vld/ap_ack word

---
 rtl/leaf_stream_packer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/leaf_stream_packer.sv
// -----------------------------------------------------------------------------
// leaf_stream_packer
//   Transmit side of a leaf interface. Takes one user word at a time from an
//   ap_vld/ap_ack producer and emits one BFT packet per word toward a remote
//   leaf. The number of packets in flight is limited by a credit window of
//   2**NUM_ADDR_BITS packets. The window is refilled by credit-return packets
//   that arrive on the inbound BFT bus.
//
//   Packet layout (PACKET_BITS = 49):
//     {vld[48], leaf[47:44], port[43:40], seq[39:33], ctrl[32], payload[31:0]}
//
//   Optional build macro:
//     PKT_CNT_EN - when defined, adds output port pkt_count. It is a 16-bit
//                  saturating count of emitted user packets. Resends are not
//                  counted.
//
// Ports
//   clk                      in   1   rising-edge clock
//   reset                    in   1   synchronous, active-high reset
//   din_leaf_user2interface  in   32  user word, held by the producer until ack
//   vld_user2interface       in   1   user word valid
//   ack_interface2user       out  1   one-cycle accept pulse to the producer
//   dest_leaf                in   4   destination leaf, sampled at accept
//   dest_port                in   4   destination port, sampled at accept
//   dout_leaf_interface2bft  out  49  outbound packet; bit 48 = valid
//   din_leaf_bft2interface   in   49  inbound packets; only credit returns are used
//   resend                   in   1   re-emit the last packet
//   credit_avail             out  1   credit counter is non-zero
//   pkt_count                out  16  emitted-packet count (PKT_CNT_EN only)
// -----------------------------------------------------------------------------
module leaf_stream_packer #(
    parameter int                 PACKET_BITS   = 49,
    parameter int                 PAYLOAD_BITS  = 32,
    parameter int                 NUM_LEAF_BITS = 4,
    parameter int                 NUM_PORT_BITS = 4,
    parameter int                 NUM_ADDR_BITS = 7,
    parameter logic [3:0]         SELF_LEAF     = 4'd2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic                      vld_user2interface,
    output logic                      ack_interface2user,
    input  logic [NUM_LEAF_BITS-1:0]  dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]  dest_port,
    output logic [PACKET_BITS-1:0]    dout_leaf_interface2bft,
    input  logic [PACKET_BITS-1:0]    din_leaf_bft2interface,
    input  logic                      resend,
    output logic                      credit_avail
`ifdef PKT_CNT_EN
    ,
    output logic [15:0]               pkt_count
`endif
);

    // The credit counter must hold the full window value, so it is one bit
    // wider than the sequence field. The sum is one bit wider again, so a
    // return of up to 255 credits cannot wrap before it is saturated.
    localparam int CRED_W   = NUM_ADDR_BITS + 1;
    localparam int SUM_W    = NUM_ADDR_BITS + 2;
    localparam int VLD_BIT  = PACKET_BITS - 1;
    localparam int CTRL_BIT = PAYLOAD_BITS;
    localparam int LEAF_LSB = PAYLOAD_BITS + 1 + NUM_ADDR_BITS + NUM_PORT_BITS;
    localparam int LEAF_MSB = LEAF_LSB + NUM_LEAF_BITS - 1;

    localparam logic [CRED_W-1:0]        MAX_CREDITS = CRED_W'(2 ** NUM_ADDR_BITS);
    localparam logic [SUM_W-1:0]         MAX_SUM     = SUM_W'(2 ** NUM_ADDR_BITS);
    localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE     = NUM_ADDR_BITS'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                     r_state;
    logic [CRED_W-1:0]          r_credits;
    logic [NUM_ADDR_BITS-1:0]   r_seq;
    logic [PACKET_BITS-1:0]     r_last_pkt;
    logic                       r_sent_any;
    logic [PAYLOAD_BITS-1:0]    r_word;
    logic [NUM_LEAF_BITS-1:0]   r_dest_leaf;
    logic [NUM_PORT_BITS-1:0]   r_dest_port;

    logic                       w_ret_hit;
    logic [CRED_W-1:0]          w_ret_amt;
    logic                       w_consume;
    logic [SUM_W-1:0]           w_sum;
    logic [CRED_W-1:0]          w_credits_next;
    logic [PACKET_BITS-1:0]     w_pkt;
    logic                       w_unused_din;

    // A credit return is a valid inbound control packet addressed to this leaf.
    assign w_ret_hit = din_leaf_bft2interface[VLD_BIT]
                     & din_leaf_bft2interface[CTRL_BIT]
                     & (din_leaf_bft2interface[LEAF_MSB:LEAF_LSB] == SELF_LEAF);

    // Payload and sequence bits of inbound packets beyond the credit amount carry no meaning here.
    assign w_unused_din = ^{din_leaf_bft2interface[LEAF_LSB-1:CTRL_BIT+1],
                            din_leaf_bft2interface[PAYLOAD_BITS-1:CRED_W]};

    // The outgoing packet is built from the latched word and destination.
    assign w_pkt = {1'b1, r_dest_leaf, r_dest_port, r_seq, 1'b0, r_word};

    assign credit_avail = (r_credits != CRED_W'(0));

    // Credit update: subtract the packet being emitted, add any return, then clamp to the window.
    always_comb begin
        w_ret_amt      = {CRED_W{1'b0}};
        w_consume      = 1'b0;
        w_credits_next = r_credits;
        if (w_ret_hit) begin
            w_ret_amt = din_leaf_bft2interface[CRED_W-1:0];
        end else begin
            w_ret_amt = {CRED_W{1'b0}};
        end
        if (r_state == SEND) begin
            w_consume = 1'b1;
        end else begin
            w_consume = 1'b0;
        end
        // SEND is entered only with credits != 0, so this subtraction never underflows.
        w_sum = {1'b0, r_credits} + {1'b0, w_ret_amt} - {{(SUM_W-1){1'b0}}, w_consume};
        if (w_sum > MAX_SUM) begin
            w_credits_next = MAX_CREDITS;
        end else begin
            w_credits_next = w_sum[CRED_W-1:0];
        end
    end

    // Main FSM: accept a word, emit its packet, or replay the last packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                 <= IDLE;
            r_credits               <= MAX_CREDITS;
            r_seq                   <= {NUM_ADDR_BITS{1'b0}};
            r_last_pkt              <= {PACKET_BITS{1'b0}};
            r_sent_any              <= 1'b0;
            r_word                  <= {PAYLOAD_BITS{1'b0}};
            r_dest_leaf             <= {NUM_LEAF_BITS{1'b0}};
            r_dest_port             <= {NUM_PORT_BITS{1'b0}};
            ack_interface2user      <= 1'b0;
            dout_leaf_interface2bft <= {PACKET_BITS{1'b0}};
        end else begin
            r_credits <= w_credits_next;
            case (r_state)
                IDLE: begin
                    ack_interface2user <= 1'b0;
                    // A resend takes priority, and any pending user word keeps waiting.
                    if (resend && r_sent_any) begin
                        dout_leaf_interface2bft <= r_last_pkt;
                    end else if (vld_user2interface && credit_avail) begin
                        r_word                  <= din_leaf_user2interface;
                        r_dest_leaf             <= dest_leaf;
                        r_dest_port             <= dest_port;
                        ack_interface2user      <= 1'b1;
                        dout_leaf_interface2bft <= {PACKET_BITS{1'b0}};
                        r_state                 <= SEND;
                    end else begin
                        dout_leaf_interface2bft <= {PACKET_BITS{1'b0}};
                    end
                end
                SEND: begin
                    ack_interface2user      <= 1'b0;
                    dout_leaf_interface2bft <= w_pkt;
                    r_last_pkt              <= w_pkt;
                    r_seq                   <= r_seq + SEQ_ONE;
                    r_sent_any              <= 1'b1;
                    r_state                 <= IDLE;
                end
                default: begin
                    ack_interface2user      <= 1'b0;
                    dout_leaf_interface2bft <= {PACKET_BITS{1'b0}};
                    r_state                 <= IDLE;
                end
            endcase
        end
    end

`ifdef PKT_CNT_EN
    logic [15:0] r_pkt_count;

    assign pkt_count = r_pkt_count;

    // Count user packets emitted from SEND; hold at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_count <= 16'h0000;
        end else if ((r_state == SEND) && (r_pkt_count != 16'hFFFF)) begin
            r_pkt_count <= r_pkt_count + 16'h0001;
        end else begin
            r_pkt_count <= r_pkt_count;
        end
    end
`endif

endmodule
